// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. At most one
// request is granted per cycle, round-robin on conflict and work-conserving
// otherwise. The granted operands drive the ALU, and the ALU result is
// captured into that requester's one-entry response register. Results appear
// one clock after the accept edge. Total throughput is one op per cycle.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   req{0,1}Valid/Ready      request handshake (accept when both high)
//   req{0,1}SrcA/SrcB/Ctrl   operands and ALU control code for the request
//   resp{0,1}Valid/Ready     response handshake (drain when both high)
//   resp{0,1}Result          held result for the requester
//   aluSrcA/aluSrcB/aluControl  operands and control to the shared ALU
//   aluResult                combinational result from the shared ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [DATA_WIDTH-1:0] req0SrcA,
  input  logic [DATA_WIDTH-1:0] req0SrcB,
  input  logic [2:0]            req0Ctrl,
  output logic                  resp0Valid,
  input  logic                  resp0Ready,
  output logic [DATA_WIDTH-1:0] resp0Result,

  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [DATA_WIDTH-1:0] req1SrcA,
  input  logic [DATA_WIDTH-1:0] req1SrcB,
  input  logic [2:0]            req1Ctrl,
  output logic                  resp1Valid,
  input  logic                  resp1Ready,
  output logic [DATA_WIDTH-1:0] resp1Result,

  output logic [DATA_WIDTH-1:0] aluSrcA,
  output logic [DATA_WIDTH-1:0] aluSrcB,
  output logic [2:0]            aluControl,
  input  logic [DATA_WIDTH-1:0] aluResult
);

  // Requester that was accepted most recently; 1 after reset so that
  // requester 0 wins the first conflict.
  logic                  last_grant;
  logic                  resp0_valid_q;
  logic                  resp1_valid_q;
  logic [DATA_WIDTH-1:0] resp0_result_q;
  logic [DATA_WIDTH-1:0] resp1_result_q;

  logic slot_free0;
  logic slot_free1;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // A slot draining this cycle is free for a same-cycle accept, which is
  // what sustains one op per cycle per requester under continuous traffic.
  assign slot_free0 = !resp0_valid_q || resp0Ready;
  assign slot_free1 = !resp1_valid_q || resp1Ready;

  assign elig0 = req0Valid && slot_free0;
  assign elig1 = req1Valid && slot_free1;

  // On conflict the requester that did not win last time is granted;
  // a lone eligible requester is granted regardless of history.
  assign grant0 = elig0 && (!elig1 ||  last_grant);
  assign grant1 = elig1 && (!elig0 || !last_grant);

  assign req0Ready = grant0;
  assign req1Ready = grant1;

  // Idle cycles drive zeros so the shared ALU sees a quiet add of 0 + 0.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    aluSrcA    = '0;
    aluSrcB    = '0;
    aluControl = 3'b000;
    if (grant0) begin
      aluSrcA    = req0SrcA;
      aluSrcB    = req0SrcB;
      aluControl = req0Ctrl;
    end else if (grant1) begin
      aluSrcA    = req1SrcA;
      aluSrcB    = req1SrcB;
      aluControl = req1Ctrl;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the result registers are reset too, because a reset must leave
      // no trace of a held result on the response outputs.
      last_grant     <= 1'b1;
      resp0_valid_q  <= 1'b0;
      resp1_valid_q  <= 1'b0;
      resp0_result_q <= '0;
      resp1_result_q <= '0;
    end else begin
      // Accept wins over drain: a same-cycle drain+accept keeps valid high
      // and replaces the held result.
      if (grant0) begin
        resp0_result_q <= aluResult;
        resp0_valid_q  <= 1'b1;
      end else if (resp0_valid_q && resp0Ready) begin
        resp0_valid_q  <= 1'b0;
      end

      if (grant1) begin
        resp1_result_q <= aluResult;
        resp1_valid_q  <= 1'b1;
      end else if (resp1_valid_q && resp1Ready) begin
        resp1_valid_q  <= 1'b0;
      end

      // History only moves on a real accept; grants are mutually exclusive.
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
    end
  end

  assign resp0Valid  = resp0_valid_q;
  assign resp1Valid  = resp1_valid_q;
  assign resp0Result = resp0_result_q;
  assign resp1Result = resp1_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with a directed table of cycles (reset, single op,
// round-robin conflict, backpressure, drain+accept, reset mid-operation),
// then with randomized traffic checked against a queue-based model of the
// two response channels. The shared ALU itself is modelled here as the
// environment the arbiter talks to.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          req0Valid, req0Ready, resp0Valid, resp0Ready;
  logic          req1Valid, req1Ready, resp1Valid, resp1Ready;
  logic [W-1:0]  req0SrcA, req0SrcB, req1SrcA, req1SrcB;
  logic [2:0]    req0Ctrl, req1Ctrl, aluControl;
  logic [W-1:0]  resp0Result, resp1Result;
  logic [W-1:0]  aluSrcA, aluSrcB, aluResult;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0Valid   (req0Valid),
    .req0Ready   (req0Ready),
    .req0SrcA    (req0SrcA),
    .req0SrcB    (req0SrcB),
    .req0Ctrl    (req0Ctrl),
    .resp0Valid  (resp0Valid),
    .resp0Ready  (resp0Ready),
    .resp0Result (resp0Result),
    .req1Valid   (req1Valid),
    .req1Ready   (req1Ready),
    .req1SrcA    (req1SrcA),
    .req1SrcB    (req1SrcB),
    .req1Ctrl    (req1Ctrl),
    .resp1Valid  (resp1Valid),
    .resp1Ready  (resp1Ready),
    .resp1Result (resp1Result),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluControl  (aluControl),
    .aluResult   (aluResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the ALU for each control code.
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [2:0]   c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (a < b) ? W'(1) : W'(0);
      3'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      3'd6:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  always_comb aluResult = alu_fn(aluSrcA, aluSrcB, aluControl);

  typedef struct {
    logic         rst_n;
    logic         v0;
    logic [W-1:0] a0, b0;
    logic [2:0]   c0;
    logic         rr0;
    logic         v1;
    logic [W-1:0] a1, b1;
    logic [2:0]   c1;
    logic         rr1;
  } stim_t;

  typedef struct {
    stim_t        s;
    logic         rdy0, rdy1;   // expected before the edge
    logic [2:0]   ctrl;         // expected aluControl before the edge
    logic         rv0;          // expected after the edge
    logic [W-1:0] res0;
    logic         rv1;
    logic [W-1:0] res1;
  } vec_t;

  function automatic stim_t st(input logic r,
                               input logic v0, input logic [W-1:0] a0,
                               input logic [W-1:0] b0, input logic [2:0] c0,
                               input logic rr0,
                               input logic v1, input logic [W-1:0] a1,
                               input logic [W-1:0] b1, input logic [2:0] c1,
                               input logic rr1);
    stim_t s;
    s.rst_n = r;
    s.v0 = v0; s.a0 = a0; s.b0 = b0; s.c0 = c0; s.rr0 = rr0;
    s.v1 = v1; s.a1 = a1; s.b1 = b1; s.c1 = c1; s.rr1 = rr1;
    return s;
  endfunction

  function automatic vec_t vec(input stim_t s, input logic rdy0,
                               input logic rdy1, input logic [2:0] ctrl,
                               input logic rv0, input logic [W-1:0] res0,
                               input logic rv1, input logic [W-1:0] res1);
    vec_t v;
    v.s = s; v.rdy0 = rdy0; v.rdy1 = rdy1; v.ctrl = ctrl;
    v.rv0 = rv0; v.res0 = res0; v.rv1 = rv1; v.res1 = res1;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    rst_n      = s.rst_n;
    req0Valid  = s.v0;  req0SrcA = s.a0; req0SrcB = s.b0; req0Ctrl = s.c0;
    resp0Ready = s.rr0;
    req1Valid  = s.v1;  req1SrcA = s.a1; req1SrcB = s.b1; req1Ctrl = s.c1;
    resp1Ready = s.rr1;
  endtask

  // Reference model: each response channel is a queue of at most one result,
  // plus the value last shown on the result output.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] hold0, hold1;
  int           last_winner;

  vec_t tbl[17];

  initial begin
    stim_t s;
    int    w;
    logic  f0, f1, e0, e1;

    // Directed cycles: reset, round-robin conflict, single op, backpressure,
    // drain+accept, reset mid-operation, idle.
    tbl[0]  = vec(st(0, 1, 1, 1, 3'd0, 1, 1, 32'hF0, 32'h0F, 3'd3, 1), 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = vec(st(0, 1, 1, 1, 3'd0, 1, 1, 32'hF0, 32'h0F, 3'd3, 1), 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = vec(st(1, 1, 1, 1, 3'd0, 1, 1, 32'hF0, 32'h0F, 3'd3, 1), 1, 0, 3'd0, 1, 2, 0, 0);
    tbl[3]  = vec(st(1, 1, 1, 1, 3'd0, 1, 1, 32'hF0, 32'h0F, 3'd3, 1), 0, 1, 3'd3, 0, 2, 1, 32'hFF);
    tbl[4]  = vec(st(1, 1, 1, 1, 3'd0, 1, 1, 32'hF0, 32'h0F, 3'd3, 1), 1, 0, 3'd0, 1, 2, 0, 32'hFF);
    tbl[5]  = vec(st(1, 1, 1, 1, 3'd0, 1, 1, 32'hF0, 32'h0F, 3'd3, 1), 0, 1, 3'd3, 0, 2, 1, 32'hFF);
    tbl[6]  = vec(st(1, 1, 5, 3, 3'd1, 1, 0, 0, 0, 3'd0, 1), 1, 0, 3'd1, 1, 2, 0, 32'hFF);
    tbl[7]  = vec(st(1, 0, 0, 0, 3'd0, 1, 1, 3, 4, 3'd0, 0), 0, 1, 3'd0, 0, 2, 1, 7);
    tbl[8]  = vec(st(1, 1, 32'hC, 32'hA, 3'd2, 1, 1, 1, 2, 3'd0, 0), 1, 0, 3'd2, 1, 8, 1, 7);
    tbl[9]  = vec(st(1, 1, 32'hC, 32'hA, 3'd2, 1, 1, 1, 2, 3'd0, 0), 1, 0, 3'd2, 1, 8, 1, 7);
    tbl[10] = vec(st(1, 1, 32'hC, 32'hA, 3'd2, 1, 1, 1, 2, 3'd0, 1), 0, 1, 3'd0, 0, 8, 1, 3);
    tbl[11] = vec(st(1, 1, 7, 2, 3'd6, 1, 0, 0, 0, 3'd0, 1), 1, 0, 3'd6, 1, 32'h1C, 0, 3);
    tbl[12] = vec(st(1, 1, 32'h8000_0000, 1, 3'd7, 1, 0, 0, 0, 3'd0, 1), 1, 0, 3'd7, 1, 32'h4000_0000, 0, 3);
    tbl[13] = vec(st(1, 1, 32'hFFFF_FFFF, 0, 3'd5, 1, 0, 0, 0, 3'd0, 1), 1, 0, 3'd5, 1, 1, 0, 3);
    tbl[14] = vec(st(0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0, 0), 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = vec(st(1, 1, 2, 3, 3'd4, 1, 1, 4, 4, 3'd1, 1), 1, 0, 3'd4, 1, 1, 0, 0);
    tbl[16] = vec(st(1, 0, 0, 0, 3'd0, 1, 0, 0, 0, 3'd0, 1), 0, 0, 3'd0, 0, 1, 0, 0);

    drive(tbl[0].s);
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].s);
      #2;
      if (tbl[i].s.rst_n) begin
        check($sformatf("dir%0d req0Ready", i), W'(req0Ready), W'(tbl[i].rdy0));
        check($sformatf("dir%0d req1Ready", i), W'(req1Ready), W'(tbl[i].rdy1));
        check($sformatf("dir%0d aluControl", i), W'(aluControl), W'(tbl[i].ctrl));
      end
      @(posedge clk); #1;
      check($sformatf("dir%0d resp0Valid", i), W'(resp0Valid), W'(tbl[i].rv0));
      check($sformatf("dir%0d resp0Result", i), resp0Result, tbl[i].res0);
      check($sformatf("dir%0d resp1Valid", i), W'(resp1Valid), W'(tbl[i].rv1));
      check($sformatf("dir%0d resp1Result", i), resp1Result, tbl[i].res1);
    end

    // Randomized traffic; the first two cycles reset DUT and model together.
    last_winner = 1;
    hold0 = '0;
    hold1 = '0;
    for (int i = 0; i < 3000; i++) begin
      s.rst_n = (i < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
      s.v0  = ($urandom_range(0, 3) != 0);
      s.v1  = ($urandom_range(0, 3) != 0);
      s.rr0 = ($urandom_range(0, 2) != 0);
      s.rr1 = ($urandom_range(0, 2) != 0);
      s.a0  = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 40));
      s.b0  = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 40));
      s.a1  = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 40));
      s.b1  = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 40));
      s.c0  = 3'($urandom_range(0, 7));
      s.c1  = 3'($urandom_range(0, 7));
      drive(s);
      #2;

      w = -1;
      if (s.rst_n) begin
        f0 = (q0.size() == 0) || s.rr0;
        f1 = (q1.size() == 0) || s.rr1;
        e0 = s.v0 && f0;
        e1 = s.v1 && f1;
        if (e0 && e1)  w = 1 - last_winner;
        else if (e0)   w = 0;
        else if (e1)   w = 1;
        check("rnd req0Ready", W'(req0Ready), W'(w == 0));
        check("rnd req1Ready", W'(req1Ready), W'(w == 1));
        check("rnd aluSrcA", aluSrcA, (w == 0) ? s.a0 : (w == 1) ? s.a1 : '0);
        check("rnd aluSrcB", aluSrcB, (w == 0) ? s.b0 : (w == 1) ? s.b1 : '0);
        check("rnd aluControl", W'(aluControl),
              W'((w == 0) ? s.c0 : (w == 1) ? s.c1 : 3'd0));
      end

      @(posedge clk); #1;

      if (!s.rst_n) begin
        q0.delete();
        q1.delete();
        hold0 = '0;
        hold1 = '0;
        last_winner = 1;
      end else begin
        if (q0.size() != 0 && s.rr0) void'(q0.pop_front());
        if (q1.size() != 0 && s.rr1) void'(q1.pop_front());
        if (w == 0) begin
          hold0 = alu_fn(s.a0, s.b0, s.c0);
          q0.push_back(hold0);
          last_winner = 0;
        end else if (w == 1) begin
          hold1 = alu_fn(s.a1, s.b1, s.c1);
          q1.push_back(hold1);
          last_winner = 1;
        end
      end
      check("rnd resp0Valid", W'(resp0Valid), W'(q0.size() != 0));
      check("rnd resp0Result", resp0Result, hold0);
      check("rnd resp1Valid", W'(resp1Valid), W'(q1.size() != 0));
      check("rnd resp1Result", resp1Result, hold1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters (e.g. two issue ports or a main pipe plus an address-generation side path).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The arbiter grants at most one request per cycle, round-robin, and drives the shared ALU from the granted request.
- It captures the result into that requester's one-entry response register. Latency is 1 cycle; throughput is 1 op/cycle total.

Parameters:
DATA_WIDTH, 32, operand/result width; passed unchanged to the ALU interface.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req0Valid  input  1  requester 0 has an op
req0Ready  output  1  requester 0 op accepted this cycle when both high
req0SrcA  input  DATA_WIDTH  operand A
req0SrcB  input  DATA_WIDTH  operand B
req0Ctrl  input  3  ALU control code (000 add, 001 sub, 010 and, 011 or, 100 sltu, 101 slt, 110 sll, 111 srl)
resp0Valid  output  1  result 0 available
resp0Ready  input  1  requester 0 consumes result
resp0Result  output  DATA_WIDTH  result for requester 0
req1Valid, req1Ready, req1SrcA, req1SrcB, req1Ctrl  as requester 0, for requester 1
resp1Valid, resp1Ready, resp1Result  as requester 0, for requester 1
aluSrcA  output  DATA_WIDTH  to shared ALU srcA
aluSrcB  output  DATA_WIDTH  to shared ALU srcB
aluControl  output  3  to shared ALU control
aluResult  input  DATA_WIDTH  from shared ALU (combinational)

Behaviour:
- State:
  - lastGrant (1 bit): requester most recently accepted.
  - respNValid and respNResult per requester.
- Reset (rst_n low at a clock edge):
  - resp0Valid = resp1Valid = 0; resp0Result = resp1Result = 0.
  - lastGrant = 1, so requester 0 wins the first conflict.
  - Reset mid-operation discards any held result; nothing is replayed.
- Slot availability: slotFreeN = !respNValid || respNReady. A response drained this cycle frees its slot for a same-cycle accept, so back-to-back ops sustain 1/cycle per requester.
- Eligibility: eligN = reqNValid && slotFreeN.
- Grant (combinational):
  - Both eligible: grant the requester != lastGrant.
  - One eligible: grant it (work-conserving, regardless of lastGrant).
  - None eligible: no grant.
- reqNReady = grant to N. It is never high for both requesters in the same cycle.
  - reqNReady may depend combinationally on the other requester's valid and on respNReady.
  - It never depends on reqNValid's own value being sampled later. Requesters must not gate reqNValid on reqNReady.
- ALU drive:
  - Granted: aluSrcA/aluSrcB/aluControl = the granted requester's operands and control.
  - No grant: all zero (control 000).
- Accept edge (reqNValid && reqNReady):
  - respNResult <= aluResult; respNValid <= 1; lastGrant <= N.
- Drain without new accept: respNValid <= 0 on (respNValid && respNReady); respNResult holds its value.
- Drain and accept for the same N in one cycle: the new result replaces the old and respNValid stays 1.
- lastGrant changes only on an actual accept; idle cycles and blocked requests leave it unchanged.
- Response stability: while respNValid && !respNReady, respNResult and respNValid hold. reqNReady is 0 for that requester; the other requester may still be granted.
- Latency: result is visible on respNResult exactly one clock after the accept edge.
- No ordering relation between the two response channels; each channel is in-order (single entry).
- Ctrl codes are passed through unchecked; all 8 codes are legal.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req0Valid=req1Valid=1 -> req0Ready=req1Ready=0 is not required during reset, but after the release edge resp0Valid=resp1Valid=0, and the first conflict grants req0.
- Single requester: req0 (A=5, B=3, Ctrl=001) with resp0Ready=1 -> req0Ready=1 same cycle; next cycle resp0Valid=1, resp0Result=2; aluControl=001 during the accept cycle.
- Conflict round-robin: both valid for 4 cycles with fresh ops (req0 A=1,B=1,add; req1 A=0xF0,B=0x0F,or) and both respReady=1 -> grants 0,1,0,1; resp0Result=2 and resp1Result=0xFF on alternate cycles.
- Backpressure: resp1Ready=0 with resp1 holding 7; req1 and req0 valid -> req1Ready=0 and req0 granted every cycle; resp1Result stays 7. Raise resp1Ready -> req1 accepted that same cycle; its new result appears next cycle.
- Drain+accept same cycle: resp0Valid=1, resp0Ready=1, req0 (A=0x80000000, B=1, srl) -> resp0Valid stays 1; next resp0Result=0x40000000; no bubble.
- Reset mid-operation: accept req0 (A=-1, B=0, slt), then assert rst_n=0 before resp0Ready -> after the reset edge resp0Valid=0 and resp0Result=0; lastGrant=1.
